step_limiter: RTL and testbench
===============================

STEP_LIMITER -- requirements
Module: step_limiter

Interface
REQ-001 SHALL have parameter WIDTH, default 13, bit width of cycle/duty/phase values.
REQ-002 SHALL have parameter TRANS_NUM, default 249, number of transducer channels.
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port UPDATE  input  1  single-cycle pulse requesting one limiting sweep.
REQ-006 SHALL have port STEP_DUTY  input  WIDTH  maximum duty change per sweep.
REQ-007 SHALL have port STEP_PHASE  input  WIDTH  maximum phase change per sweep.
REQ-008 SHALL have port CYCLE  input  WIDTH x TRANS_NUM  per-channel PWM period.
REQ-009 SHALL have port DUTY_IN  input  WIDTH x TRANS_NUM  target duty.
REQ-010 SHALL have port PHASE_IN  input  WIDTH x TRANS_NUM  target phase.
REQ-011 SHALL have port DUTY  output  WIDTH x TRANS_NUM  limited duty, feeds PWM stage.
REQ-012 SHALL have port PHASE  output  WIDTH x TRANS_NUM  limited phase, feeds PWM stage.
REQ-013 SHALL have port BUSY  output  1  high while a sweep is in progress.
REQ-014 SHALL have port DONE  output  1  one-cycle pulse at sweep end.

Function
REQ-015 SHALL use one shared time-multiplexed datapath; FSM states IDLE, FETCH, CALC, FINISH.
REQ-016 IDLE->FETCH on UPDATE (or pending flag); channel index reset to 0; BUSY high from the next cycle.
REQ-017 FETCH: register CYCLE[i], DUTY_IN[i], PHASE_IN[i], DUTY[i], PHASE[i]; ->CALC.
REQ-018 CALC: write DUTY[i], PHASE[i]; if i==TRANS_NUM-1 ->FINISH, else i+1, ->FETCH.
REQ-019 FINISH: DONE=1 for one cycle, BUSY=0; ->FETCH if pending, else ->IDLE.
REQ-020 Sweep latency: DONE asserted exactly 2*TRANS_NUM+1 cycles after the UPDATE cycle.
REQ-021 UPDATE while BUSY SHALL set a single pending flag, cleared on restart; extra pulses are merged.
REQ-022 Duty target SHALL be clamped to CYCLE[i]; the move toward it is min(|target-current|, STEP_DUTY), without overshoot.
REQ-023 Phase target SHALL be clamped to CYCLE[i]-1; d=(target-current) mod CYCLE[i].
REQ-024 If d <= CYCLE[i]/2 (floor), phase advances min(d, STEP_PHASE); else retreats min(CYCLE[i]-d, STEP_PHASE); result wraps modulo CYCLE[i].
REQ-025 Tie d==CYCLE[i]/2 SHALL advance forward.
REQ-026 Arithmetic SHALL use WIDTH+1 bits internally; no output exceeds CYCLE[i] (duty) or CYCLE[i]-1 (phase).
REQ-027 STEP=0 SHALL hold the corresponding value; STEP>=CYCLE SHALL reach the target in one sweep.
REQ-028 Inputs SHALL be sampled per channel in FETCH; changes mid-sweep affect only channels not yet fetched.
REQ-029 Channels not yet processed SHALL keep their previous outputs during a sweep.

Reset
REQ-030 RST SHALL asynchronously force DUTY, PHASE to 0, BUSY and DONE to 0, FSM to IDLE, index to 0, pending to 0.
REQ-031 Reset mid-sweep SHALL abort it; no DONE SHALL be produced for the aborted sweep.

Configuration
REQ-032 Macro STEP_LIMITER_PHASE_EN defined: phase limited per REQ-023..025.
REQ-033 Macro STEP_LIMITER_PHASE_EN undefined: PHASE[i] takes the clamped PHASE_IN[i] in CALC, STEP_PHASE is unused, and timing is unchanged.

Structure
REQ-034 Package step_limiter_pkg SHALL hold the FSM state enum and the default WIDTH/TRANS_NUM constants.
REQ-035 Sub-module step_limiter_calc SHALL hold the combinational per-channel duty/phase computation.

Verification
REQ-036 Duty up: CYCLE=4096, DUTY=0, target 2048, STEP_DUTY=100 -> 100, 200, ... over sweeps; 2048 reached on sweep 21, no overshoot.
REQ-037 Phase wrap: CYCLE=4096, PHASE=4000, target 50, STEP_PHASE=64 -> 4064, then 32 (wrapped), then 50.
REQ-038 Backward: CYCLE=4096, PHASE=100, target 4000 -> 36, then 4068, then 4004, then 4000.
REQ-039 Timing: UPDATE at cycle t, TRANS_NUM=249 -> DONE at t+499; second UPDATE at t+10 -> next sweep starts at t+500.
REQ-040 Clamp: CYCLE=1000, duty target 1500, phase target 1200, STEP=4095 -> DUTY=1000, PHASE=999 after one sweep.
REQ-041 Reset: RST at cycle 150 of a sweep -> all outputs 0 immediately, no DONE, next UPDATE sweeps normally.

Source files
------------

// File: rtl/step_limiter_pkg.sv
// Shared definitions for the step limiter.
// Holds the sweep FSM state encoding, the default WIDTH / TRANS_NUM values
// and a helper that sizes the channel index register.
package step_limiter_pkg;

    localparam int WIDTH_DEF     = 13;
    localparam int TRANS_NUM_DEF = 249;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_CALC   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Bits needed to index n channels (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/step_limiter_calc.sv
// Combinational per-channel limiter for one channel of the sweep.
//
// Ports:
//   cycle_i      PWM period of the channel
//   duty_tgt_i   requested duty (clamped to cycle_i)
//   phase_tgt_i  requested phase (clamped to cycle_i-1)
//   duty_cur_i   duty currently driven to the PWM stage
//   phase_cur_i  phase currently driven to the PWM stage
//   step_duty_i  largest duty move allowed per sweep
//   step_phase_i largest phase move allowed per sweep
//   duty_o       new duty, never beyond cycle_i and never past the target
//   phase_o      new phase, always in [0, cycle_i-1]
//
// Build option: STEP_LIMITER_PHASE_EN. When defined the phase moves along the
// shorter way round the period, limited by step_phase_i. When undefined the
// phase jumps directly to the clamped target and step_phase_i is ignored.
module step_limiter_calc #(
    parameter int WIDTH = 13
) (
    input  logic [WIDTH-1:0] cycle_i,
    input  logic [WIDTH-1:0] duty_tgt_i,
    input  logic [WIDTH-1:0] phase_tgt_i,
    input  logic [WIDTH-1:0] duty_cur_i,
    input  logic [WIDTH-1:0] phase_cur_i,
    input  logic [WIDTH-1:0] step_duty_i,
    input  logic [WIDTH-1:0] step_phase_i,
    output logic [WIDTH-1:0] duty_o,
    output logic [WIDTH-1:0] phase_o
);

    // One extra bit so that target+cycle and cur+move never overflow.
    localparam int W1 = WIDTH + 1;

    logic [W1-1:0] cyc_s;
    logic [W1-1:0] dt_s;
    logic [W1-1:0] dc_s;
    logic [W1-1:0] ddiff_s;
    logic [W1-1:0] dstep_s;
    logic [W1-1:0] dmove_s;
    logic [W1-1:0] dnew_s;
    logic [W1-1:0] pmax_s;
    logic [W1-1:0] pt_s;

    // Duty: clamp both ends to the period, then move toward target by at most one step.
    always_comb begin
        cyc_s   = {1'b0, cycle_i};
        dstep_s = {1'b0, step_duty_i};
        dt_s    = ({1'b0, duty_tgt_i} > cyc_s) ? cyc_s : {1'b0, duty_tgt_i};
        // A shrunken period can leave the current duty above it; pull it in first.
        dc_s    = ({1'b0, duty_cur_i} > cyc_s) ? cyc_s : {1'b0, duty_cur_i};
        ddiff_s = (dt_s >= dc_s) ? (dt_s - dc_s) : (dc_s - dt_s);
        dmove_s = (ddiff_s < dstep_s) ? ddiff_s : dstep_s;
        dnew_s  = (dt_s >= dc_s) ? (dc_s + dmove_s) : (dc_s - dmove_s);
        duty_o  = dnew_s[WIDTH-1:0];
    end

    // Highest legal phase; a zero period pins the phase to zero.
    always_comb begin
        pmax_s = (cyc_s == {W1{1'b0}}) ? {W1{1'b0}} : (cyc_s - W1'(1));
        pt_s   = ({1'b0, phase_tgt_i} > pmax_s) ? pmax_s : {1'b0, phase_tgt_i};
    end

`ifdef STEP_LIMITER_PHASE_EN
    logic [W1-1:0] pc_s;
    logic [W1-1:0] d_s;
    logic [W1-1:0] half_s;
    logic [W1-1:0] back_s;
    logic [W1-1:0] pstep_s;
    logic [W1-1:0] fmove_s;
    logic [W1-1:0] fsum_s;
    logic [W1-1:0] fnew_s;
    logic [W1-1:0] bmove_s;
    logic [W1-1:0] bnew_s;

    // Phase: take the shorter way round the circle; a tie at half a period goes forward.
    always_comb begin
        pstep_s = {1'b0, step_phase_i};
        pc_s    = ({1'b0, phase_cur_i} > pmax_s) ? pmax_s : {1'b0, phase_cur_i};
        // Forward distance (target - current) mod cycle, both operands already < cycle.
        d_s     = (pt_s >= pc_s) ? (pt_s - pc_s) : (pt_s + cyc_s - pc_s);
        half_s  = cyc_s >> 1;
        back_s  = cyc_s - d_s;
        fmove_s = (d_s < pstep_s) ? d_s : pstep_s;
        fsum_s  = pc_s + fmove_s;
        fnew_s  = (fsum_s >= cyc_s) ? (fsum_s - cyc_s) : fsum_s;
        bmove_s = (back_s < pstep_s) ? back_s : pstep_s;
        bnew_s  = (pc_s >= bmove_s) ? (pc_s - bmove_s) : (pc_s + cyc_s - bmove_s);
        phase_o = (d_s <= half_s) ? fnew_s[WIDTH-1:0] : bnew_s[WIDTH-1:0];
    end
`else
    // Phase limiting disabled: the current phase and phase step play no part.
    logic unused_phase_s;
    assign unused_phase_s = ^{step_phase_i, phase_cur_i};

    // Phase follows the clamped target directly.
    always_comb begin
        phase_o = pt_s[WIDTH-1:0];
    end
`endif

endmodule

// File: rtl/step_limiter.sv
// Slew-rate limiter for the per-channel duty/phase values of a PWM array.
// Each UPDATE pulse triggers one sweep over all TRANS_NUM channels through a
// single shared datapath (step_limiter_calc), two cycles per channel
// (FETCH then CALC), followed by a one-cycle FINISH that pulses DONE.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   UPDATE            request a sweep; while busy it is remembered once
//   STEP_DUTY/PHASE   maximum change per sweep
//   CYCLE, DUTY_IN, PHASE_IN  flat per-channel period and targets
//   DUTY, PHASE       registered limited values for the PWM stage
//   BUSY              high during FETCH/CALC
//   DONE              one-cycle pulse in the FINISH cycle
//
// Build option: STEP_LIMITER_PHASE_EN (see step_limiter_calc).
module step_limiter
    import step_limiter_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int TRANS_NUM = TRANS_NUM_DEF
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       UPDATE,
    input  logic [WIDTH-1:0]           STEP_DUTY,
    input  logic [WIDTH-1:0]           STEP_PHASE,
    input  logic [WIDTH*TRANS_NUM-1:0] CYCLE,
    input  logic [WIDTH*TRANS_NUM-1:0] DUTY_IN,
    input  logic [WIDTH*TRANS_NUM-1:0] PHASE_IN,
    output logic [WIDTH*TRANS_NUM-1:0] DUTY,
    output logic [WIDTH*TRANS_NUM-1:0] PHASE,
    output logic                       BUSY,
    output logic                       DONE
);

    localparam int IDX_W  = idx_width(TRANS_NUM);
    localparam int BASE_W = $clog2(WIDTH * TRANS_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRANS_NUM - 1);

    state_t state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       pending_q, pending_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [WIDTH-1:0]           cyc_q, cyc_d;
    logic [WIDTH-1:0]           dtgt_q, dtgt_d;
    logic [WIDTH-1:0]           ptgt_q, ptgt_d;
    logic [WIDTH-1:0]           dcur_q, dcur_d;
    logic [WIDTH-1:0]           pcur_q, pcur_d;
    logic [WIDTH*TRANS_NUM-1:0] duty_q, duty_d;
    logic [WIDTH*TRANS_NUM-1:0] phase_q, phase_d;
    logic [BASE_W-1:0]          base_s;
    logic [WIDTH-1:0]           calc_duty_s;
    logic [WIDTH-1:0]           calc_phase_s;

    step_limiter_calc #(
        .WIDTH(WIDTH)
    ) u_calc (
        .cycle_i     (cyc_q),
        .duty_tgt_i  (dtgt_q),
        .phase_tgt_i (ptgt_q),
        .duty_cur_i  (dcur_q),
        .phase_cur_i (pcur_q),
        .step_duty_i (STEP_DUTY),
        .step_phase_i(STEP_PHASE),
        .duty_o      (calc_duty_s),
        .phase_o     (calc_phase_s)
    );

    // Sweep FSM: next state, channel index, pending request, operand capture and output write-back.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        cyc_d     = cyc_q;
        dtgt_d    = dtgt_q;
        ptgt_d    = ptgt_q;
        dcur_d    = dcur_q;
        pcur_d    = pcur_q;
        duty_d    = duty_q;
        phase_d   = phase_q;
        base_s    = BASE_W'(idx_q) * BASE_W'(WIDTH);

        case (state_q)
            ST_IDLE: begin
                if (UPDATE || pending_q) begin
                    state_d   = ST_FETCH;
                    idx_d     = {IDX_W{1'b0}};
                    pending_d = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // Inputs are sampled here, so later changes only reach unfetched channels.
                cyc_d   = CYCLE[base_s +: WIDTH];
                dtgt_d  = DUTY_IN[base_s +: WIDTH];
                ptgt_d  = PHASE_IN[base_s +: WIDTH];
                dcur_d  = duty_q[base_s +: WIDTH];
                pcur_d  = phase_q[base_s +: WIDTH];
                state_d = ST_CALC;
                if (UPDATE) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
            end
            ST_CALC: begin
                duty_d[base_s +: WIDTH]  = calc_duty_s;
                phase_d[base_s +: WIDTH] = calc_phase_s;
                if (UPDATE) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_FINISH: begin
                // A request landing in the FINISH cycle itself also restarts at once.
                if (pending_q || UPDATE) begin
                    state_d   = ST_FETCH;
                    idx_d     = {IDX_W{1'b0}};
                    pending_d = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                idx_d     = {IDX_W{1'b0}};
                pending_d = 1'b0;
            end
        endcase

        // BUSY and DONE are registered decodes of the state being entered.
        busy_d = (state_d == ST_FETCH) || (state_d == ST_CALC);
        done_d = (state_d == ST_FINISH);
    end

    // State, index, operands and outputs; reset aborts any sweep without a DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            idx_q     <= {IDX_W{1'b0}};
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cyc_q     <= {WIDTH{1'b0}};
            dtgt_q    <= {WIDTH{1'b0}};
            ptgt_q    <= {WIDTH{1'b0}};
            dcur_q    <= {WIDTH{1'b0}};
            pcur_q    <= {WIDTH{1'b0}};
            duty_q    <= {(WIDTH*TRANS_NUM){1'b0}};
            phase_q   <= {(WIDTH*TRANS_NUM){1'b0}};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cyc_q     <= cyc_d;
            dtgt_q    <= dtgt_d;
            ptgt_q    <= ptgt_d;
            dcur_q    <= dcur_d;
            pcur_q    <= pcur_d;
            duty_q    <= duty_d;
            phase_q   <= phase_d;
        end
    end

    assign DUTY  = duty_q;
    assign PHASE = phase_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_step_limiter.sv
// Self-checking bench for step_limiter (default parameters).
// A behavioural model computes every channel's next duty/phase when a sweep
// is requested and pushes the results to a scoreboard queue; the entries are
// popped and compared against DUTY/PHASE when DONE is seen.
module tb_step_limiter;

    localparam int W = 13;
    localparam int N = 249;

    typedef struct {
        int ch;
        int duty;
        int phase;
    } exp_t;

    logic             CLK;
    logic             RST;
    logic             UPDATE;
    logic [W-1:0]     STEP_DUTY;
    logic [W-1:0]     STEP_PHASE;
    logic [W*N-1:0]   CYCLE;
    logic [W*N-1:0]   DUTY_IN;
    logic [W*N-1:0]   PHASE_IN;
    logic [W*N-1:0]   DUTY;
    logic [W*N-1:0]   PHASE;
    logic             BUSY;
    logic             DONE;

    int   tests_run;
    int   tests_failed;
    int   cyc_a [N];
    int   dt_a  [N];
    int   pt_a  [N];
    int   m_d   [N];
    int   m_p   [N];
    int   step_duty_v;
    int   step_phase_v;
    exp_t sb_q[$];

    step_limiter #(
        .WIDTH    (W),
        .TRANS_NUM(N)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .UPDATE    (UPDATE),
        .STEP_DUTY (STEP_DUTY),
        .STEP_PHASE(STEP_PHASE),
        .CYCLE     (CYCLE),
        .DUTY_IN   (DUTY_IN),
        .PHASE_IN  (PHASE_IN),
        .DUTY      (DUTY),
        .PHASE     (PHASE),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int m_duty(input int cyc, input int tgt, input int cur, input int step);
        int t;
        int c;
        t = (tgt > cyc) ? cyc : tgt;
        c = (cur > cyc) ? cyc : cur;
        if (t > c) return c + (((t - c) < step) ? (t - c) : step);
        else       return c - (((c - t) < step) ? (c - t) : step);
    endfunction

    function automatic int m_phase(input int cyc, input int tgt, input int cur, input int step);
        int t;
        int c;
        int d;
        int mv;
        if (cyc == 0) return 0;
        t = (tgt > cyc - 1) ? cyc - 1 : tgt;
`ifdef STEP_LIMITER_PHASE_EN
        c = (cur > cyc - 1) ? cyc - 1 : cur;
        d = (((t - c) % cyc) + cyc) % cyc;
        if (2 * d <= cyc) begin
            mv = (d < step) ? d : step;
            return (c + mv) % cyc;
        end else begin
            mv = ((cyc - d) < step) ? (cyc - d) : step;
            return (((c - mv) % cyc) + cyc) % cyc;
        end
`else
        c  = cur;
        d  = c;
        mv = step + d;
        return t;
`endif
    endfunction

    task automatic apply_inputs();
        for (int ch = 0; ch < N; ch++) begin
            CYCLE[ch*W +: W]    = W'(cyc_a[ch]);
            DUTY_IN[ch*W +: W]  = W'(dt_a[ch]);
            PHASE_IN[ch*W +: W] = W'(pt_a[ch]);
        end
        STEP_DUTY  = W'(step_duty_v);
        STEP_PHASE = W'(step_phase_v);
    endtask

    task automatic model_sweep();
        for (int ch = 0; ch < N; ch++) begin
            m_d[ch] = m_duty(cyc_a[ch], dt_a[ch], m_d[ch], step_duty_v);
            m_p[ch] = m_phase(cyc_a[ch], pt_a[ch], m_p[ch], step_phase_v);
            sb_q.push_back('{ch, m_d[ch], m_p[ch]});
        end
    endtask

    task automatic check_sweep(input string name);
        exp_t e;
        logic [W-1:0] dv;
        logic [W-1:0] pv;
        for (int k = 0; k < N; k++) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL %s scoreboard: observed empty queue, expected %0d entries", name, N - k);
                break;
            end
            e  = sb_q.pop_front();
            dv = DUTY[e.ch*W +: W];
            pv = PHASE[e.ch*W +: W];
            if (dv !== W'(e.duty)) begin
                tests_failed++;
                $display("FAIL %s duty[%0d]: observed %0d, expected %0d", name, e.ch, dv, e.duty);
            end
            tests_run++;
            if (pv !== W'(e.phase)) begin
                tests_failed++;
                $display("FAIL %s phase[%0d]: observed %0d, expected %0d", name, e.ch, pv, e.phase);
            end
        end
    endtask

    task automatic do_sweep(input string name);
        int n;
        bit seen;
        apply_inputs();
        model_sweep();
        UPDATE = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 1000) begin
            tick();
            n++;
            UPDATE = 1'b0;
            if (DONE === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen || n != 2*N+1) begin
            tests_failed++;
            $display("FAIL %s latency: observed %0d cycles (done %0b), expected %0d", name, n, seen, 2*N+1);
        end
        check_sweep(name);
    endtask

    task automatic test_reset();
        tests_run++;
        if (DUTY !== '0) begin
            tests_failed++;
            $display("FAIL reset_duty: observed %0d nonzero bits, expected 0", $countones(DUTY));
        end
        tests_run++;
        if (PHASE !== '0) begin
            tests_failed++;
            $display("FAIL reset_phase: observed %0d nonzero bits, expected 0", $countones(PHASE));
        end
        tests_run++;
        if (BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: observed %b, expected 0", BUSY);
        end
        tests_run++;
        if (DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done: observed %b, expected 0", DONE);
        end
    endtask

    task automatic test_duty_up();
        int exp_d;
        step_duty_v  = 100;
        step_phase_v = 0;
        for (int k = 1; k <= 21; k++) begin
            do_sweep("duty_up");
            exp_d = (100 * k > 2048) ? 2048 : 100 * k;
            tests_run++;
            if (DUTY[0 +: W] !== W'(exp_d)) begin
                tests_failed++;
                $display("FAIL duty_up_ch0 sweep %0d: observed %0d, expected %0d", k, DUTY[0 +: W], exp_d);
            end
        end
    endtask

    task automatic test_phase();
        int e1 [4];
        int e2 [4];
`ifdef STEP_LIMITER_PHASE_EN
        e1 = '{4064, 32, 50, 50};
        e2 = '{36, 4068, 4004, 4000};
`else
        e1 = '{50, 50, 50, 50};
        e2 = '{4000, 4000, 4000, 4000};
`endif
        pt_a[1] = 4000;
        pt_a[2] = 100;
        step_phase_v = 4095;
        do_sweep("phase_setup");
        pt_a[1] = 50;
        pt_a[2] = 4000;
        step_phase_v = 64;
        for (int k = 0; k < 4; k++) begin
            do_sweep("phase_move");
            tests_run++;
            if (PHASE[1*W +: W] !== W'(e1[k])) begin
                tests_failed++;
                $display("FAIL phase_wrap step %0d: observed %0d, expected %0d", k, PHASE[1*W +: W], e1[k]);
            end
            tests_run++;
            if (PHASE[2*W +: W] !== W'(e2[k])) begin
                tests_failed++;
                $display("FAIL phase_back step %0d: observed %0d, expected %0d", k, PHASE[2*W +: W], e2[k]);
            end
        end
    endtask

    task automatic test_clamp();
        cyc_a[3] = 1000;
        dt_a[3]  = 1500;
        pt_a[3]  = 1200;
        step_duty_v  = 4095;
        step_phase_v = 4095;
        do_sweep("clamp");
        tests_run++;
        if (DUTY[3*W +: W] !== W'(1000)) begin
            tests_failed++;
            $display("FAIL clamp_duty: observed %0d, expected 1000", DUTY[3*W +: W]);
        end
        tests_run++;
        if (PHASE[3*W +: W] !== W'(999)) begin
            tests_failed++;
            $display("FAIL clamp_phase: observed %0d, expected 999", PHASE[3*W +: W]);
        end
    endtask

    task automatic test_step_zero();
        int prev;
        prev = m_d[0];
        step_duty_v  = 0;
        step_phase_v = 0;
        dt_a[0] = 10;
        for (int ch = 4; ch < N; ch++) begin
            dt_a[ch] = $urandom_range(0, 8191);
            pt_a[ch] = $urandom_range(0, 8191);
        end
        do_sweep("step_zero");
        tests_run++;
        if (DUTY[0 +: W] !== W'(prev)) begin
            tests_failed++;
            $display("FAIL step_zero_hold: observed %0d, expected %0d", DUTY[0 +: W], prev);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int first;
        int second;
        int extra;
        step_duty_v  = 37;
        step_phase_v = 21;
        apply_inputs();
        model_sweep();
        model_sweep();
        UPDATE = 1'b1;
        n = 0;
        first = -1;
        second = -1;
        while (n < 1200 && second < 0) begin
            tick();
            n++;
            UPDATE = (n == 10 || n == 20);
            if (n == 1 || n == 500) begin
                tests_run++;
                if (BUSY !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_busy at %0d: observed %b, expected 1", n, BUSY);
                end
            end
            if (n == 499) begin
                tests_run++;
                if (BUSY !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_busy_finish: observed %b, expected 0", BUSY);
                end
            end
            if (DONE === 1'b1) begin
                if (first < 0) begin
                    first = n;
                    check_sweep("b2b_first");
                end else begin
                    second = n;
                    check_sweep("b2b_second");
                end
            end
        end
        UPDATE = 1'b0;
        tests_run++;
        if (first != 2*N+1) begin
            tests_failed++;
            $display("FAIL b2b_first_done: observed %0d, expected %0d", first, 2*N+1);
        end
        tests_run++;
        if (second != 4*N+2) begin
            tests_failed++;
            $display("FAIL b2b_second_done: observed %0d, expected %0d", second, 4*N+2);
        end
        extra = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (DONE === 1'b1) extra++;
        end
        tests_run++;
        if (extra != 0) begin
            tests_failed++;
            $display("FAIL b2b_merge: observed %0d extra done pulses, expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        step_duty_v  = 500;
        step_phase_v = 500;
        apply_inputs();
        UPDATE = 1'b1;
        tick();
        UPDATE = 1'b0;
        repeat (149) tick();
        RST = 1'b1;
        #1;
        tests_run++;
        if (DUTY !== '0 || PHASE !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: observed %0d nonzero bits, expected 0",
                     $countones(DUTY) + $countones(PHASE));
        end
        tests_run++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_flags: observed busy %b done %b, expected 0 0", BUSY, DONE);
        end
        tick();
        tick();
        RST = 1'b0;
        for (int ch = 0; ch < N; ch++) begin
            m_d[ch] = 0;
            m_p[ch] = 0;
        end
        dones = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (DONE === 1'b1) dones++;
        end
        tests_run++;
        if (dones != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_no_done: observed %0d done pulses, expected 0", dones);
        end
        do_sweep("after_reset");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RST          = 1'b1;
        UPDATE       = 1'b0;
        step_duty_v  = 0;
        step_phase_v = 0;
        for (int ch = 0; ch < N; ch++) begin
            m_d[ch] = 0;
            m_p[ch] = 0;
            if (ch < 4) begin
                cyc_a[ch] = 4096;
                dt_a[ch]  = 2048;
                pt_a[ch]  = 0;
            end else if (ch < 8) begin
                cyc_a[ch] = ch - 4;
                dt_a[ch]  = 7;
                pt_a[ch]  = 7;
            end else begin
                cyc_a[ch] = $urandom_range(1, 8191);
                dt_a[ch]  = $urandom_range(0, 8191);
                pt_a[ch]  = $urandom_range(0, 8191);
            end
        end
        apply_inputs();
        repeat (3) tick();
        test_reset();
        RST = 1'b0;
        tick();
        test_duty_up();
        test_phase();
        test_clamp();
        test_step_zero();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
